prod_accum: RTL and testbench

- Streaming accumulator that sits directly downstream of the 2-bit × 2-bit product stage.
- Accepts 4-bit products over a valid/ready handshake and sums a group of up to `NUM_TERMS` of them into an `ACC_W`-bit result.
- Presents the result on a valid/ready output with term count and sticky overflow.
- Used to build small dot products from the combinational multiplier output.

---
 rtl/prod_accum_pkg.sv | 18 +
 rtl/prod_accum.sv | 110 +++++++++++
 tb/tb_prod_accum.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the product accumulator.
package prod_accum_pkg;

  // Width of one incoming 2x2 product.
  localparam int unsigned PROD_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } state_e;

  // Term counter must hold values 0..num_terms inclusive.
  function automatic int unsigned cnt_width(int unsigned num_terms);
    return $clog2(num_terms + 1);
  endfunction

endpackage

// File: rtl/prod_accum.sv
// Streaming accumulator: sums a group of up to NUM_TERMS 4-bit products and
// presents the result, beat count and sticky overflow over valid/ready.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int unsigned NUM_TERMS = 4,
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned CNT_W     = cnt_width(NUM_TERMS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  // Elaboration-time parameter sanity checks.
  if (ACC_W < PROD_W) begin : gen_acc_w_check
    $error("prod_accum: ACC_W must be at least PROD_W");
  end
  if (NUM_TERMS < 1) begin : gen_num_terms_check
    $error("prod_accum: NUM_TERMS must be at least 1");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   sum_ext;

  // Ready is a pure function of state (and held low during reset).
  assign in_ready = rst_n && (state_q != StOut);
  assign accept   = in_valid && in_ready;
  // One extra bit captures the carry out of the accumulator.
  assign sum_ext  = {1'b0, acc_q} + {1'b0, ACC_W'(in_data)};

  // Next-state, accumulator, count and overflow update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = ACC_W'(in_data);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (in_last || NUM_TERMS == 1) ? StOut : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          acc_d = sum_ext[ACC_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | sum_ext[ACC_W];
          if (in_last || cnt_d == CNT_W'(NUM_TERMS)) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are taken straight from registers.
  always_comb begin
    out_valid = (state_q == StOut);
    out_sum   = acc_q;
    out_count = cnt_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: three instances (default, ACC_W=5,
// NUM_TERMS=1), a reference model at group level, and a decoupled monitor.
module tb_prod_accum;

  typedef struct packed {
    int   sum;
    int   cnt;
    logic ovf;
  } exp_t;

  logic       clk;
  logic       rst_n     [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [3:0] in_data   [3];
  logic       in_last   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic       out_ovf   [3];

  logic [7:0] sum_a;
  logic [4:0] sum_b;
  logic [7:0] sum_c;
  logic [2:0] cnt_a;
  logic [2:0] cnt_b;
  logic [0:0] cnt_c;

  int osum [3];
  int ocnt [3];

  int n_checks = 0;
  int n_fail   = 0;

  int   psum  [3];
  int   pcnt  [3];
  int   rmode [3];
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  bit hold [3];
  int hsum [3];
  int hcnt [3];
  bit hovf [3];
  int last_sum [3];
  int last_cnt [3];
  int last_ovf [3];

  prod_accum u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .in_data  (in_data[0]),
    .in_last  (in_last[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_sum  (sum_a),
    .out_count(cnt_a),
    .out_ovf  (out_ovf[0])
  );

  prod_accum #(.NUM_TERMS(4), .ACC_W(5)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .in_data  (in_data[1]),
    .in_last  (in_last[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_sum  (sum_b),
    .out_count(cnt_b),
    .out_ovf  (out_ovf[1])
  );

  prod_accum #(.NUM_TERMS(1), .ACC_W(8)) u_dut_c (
    .clk      (clk),
    .rst_n    (rst_n[2]),
    .in_valid (in_valid[2]),
    .in_ready (in_ready[2]),
    .in_data  (in_data[2]),
    .in_last  (in_last[2]),
    .out_valid(out_valid[2]),
    .out_ready(out_ready[2]),
    .out_sum  (sum_c),
    .out_count(cnt_c),
    .out_ovf  (out_ovf[2])
  );

  always_comb begin
    osum[0] = int'(sum_a);
    osum[1] = int'(sum_b);
    osum[2] = int'(sum_c);
    ocnt[0] = int'(cnt_a);
    ocnt[1] = int'(cnt_b);
    ocnt[2] = int'(cnt_c);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int nt(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int aw(int k);
    return (k == 1) ? 5 : 8;
  endfunction

  function automatic int qsize(int k);
    case (k)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic void push_exp(int k, exp_t e);
    case (k)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop_exp(int k);
    case (k)
      0:       return qa.pop_front();
      1:       return qb.pop_front();
      default: return qc.pop_front();
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Group-level model: a group closes on last or when NUM_TERMS beats are in;
  // the result is the true sum reduced mod 2^ACC_W, overflow if it ever wrapped.
  function automatic bit model_beat(int k, int d, bit last);
    exp_t e;
    psum[k] += d;
    pcnt[k]++;
    if (last || pcnt[k] == nt(k)) begin
      e.sum = psum[k] % (1 << aw(k));
      e.cnt = pcnt[k];
      e.ovf = (psum[k] >= (1 << aw(k)));
      push_exp(k, e);
      psum[k] = 0;
      pcnt[k] = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Offer one beat; it is taken at the first rising edge where in_ready is high.
  task automatic send(int k, int d, bit last);
    int  waited;
    bit  closed;
    waited = 0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = 4'(d);
    in_last[k]  = last;
    while (!in_ready[k] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[k]) begin
      fail_now($sformatf("send_timeout[%0d]", k));
      in_valid[k] = 1'b0;
      return;
    end
    closed = model_beat(k, d, last);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
    if (closed) begin
      @(negedge clk);
      check($sformatf("latency_out_valid[%0d]", k), int'(out_valid[k]), 1);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(int k);
    int t;
    t = 0;
    while (qsize(k) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain[%0d]", k), qsize(k), 0);
    @(negedge clk);
  endtask

  task automatic rand_run(int k);
    for (int i = 0; i < 60; i++) begin
      send(k, int'($urandom_range(15)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
  endtask

  // Consumer side: random, forced-low or forced-high ready per instance.
  initial begin
    for (int k = 0; k < 3; k++) out_ready[k] = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        case (rmode[k])
          0:       out_ready[k] = ($urandom_range(0, 2) != 0);
          1:       out_ready[k] = 1'b0;
          default: out_ready[k] = 1'b1;
        endcase
      end
    end
  end

  // Monitor: compares each handshaken result with the scoreboard and checks
  // that a presented result stays put until it is taken.
  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) hold[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_n[k] && out_valid[k]) begin
          if (hold[k]) begin
            check($sformatf("hold_sum[%0d]", k), osum[k], hsum[k]);
            check($sformatf("hold_cnt[%0d]", k), ocnt[k], hcnt[k]);
            check($sformatf("hold_ovf[%0d]", k), int'(out_ovf[k]), int'(hovf[k]));
          end
          if (out_ready[k]) begin
            if (qsize(k) == 0) begin
              fail_now($sformatf("unexpected_result[%0d] sum=%0d", k, osum[k]));
            end else begin
              e = pop_exp(k);
              check($sformatf("sum[%0d]", k), osum[k], e.sum);
              check($sformatf("count[%0d]", k), ocnt[k], e.cnt);
              check($sformatf("ovf[%0d]", k), int'(out_ovf[k]), int'(e.ovf));
            end
            last_sum[k] = osum[k];
            last_cnt[k] = ocnt[k];
            last_ovf[k] = int'(out_ovf[k]);
            hold[k]     = 1'b0;
          end else begin
            hold[k] = 1'b1;
            hsum[k] = osum[k];
            hcnt[k] = ocnt[k];
            hovf[k] = out_ovf[k];
          end
        end else begin
          if (hold[k] && rst_n[k]) fail_now($sformatf("out_valid_dropped[%0d]", k));
          hold[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    int t;
    for (int k = 0; k < 3; k++) begin
      rst_n[k]    = 1'b0;
      in_valid[k] = 1'b0;
      in_data[k]  = 4'd0;
      in_last[k]  = 1'b0;
      psum[k]     = 0;
      pcnt[k]     = 0;
      rmode[k]    = 2;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid[%0d]", k), int'(out_valid[k]), 0);
      check($sformatf("rst_in_ready[%0d]", k), int'(in_ready[k]), 0);
      check($sformatf("rst_sum[%0d]", k), osum[k], 0);
      check($sformatf("rst_cnt[%0d]", k), ocnt[k], 0);
      check($sformatf("rst_ovf[%0d]", k), int'(out_ovf[k]), 0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("ready_after_rst[%0d]", k), int'(in_ready[k]), 1);

    // Full group 9,9,9,9
    for (int i = 0; i < 4; i++) send(0, 9, 1'b0);
    wait_drain(0);
    check("full_sum", last_sum[0], 36);
    check("full_cnt", last_cnt[0], 4);
    check("full_ovf", last_ovf[0], 0);

    // Early close, then a clean 4-beat group
    send(0, 3, 1'b0);
    send(0, 6, 1'b1);
    wait_drain(0);
    check("early_sum", last_sum[0], 9);
    check("early_cnt", last_cnt[0], 2);
    for (int i = 0; i < 4; i++) send(0, 1, 1'b0);
    wait_drain(0);
    check("clean_sum", last_sum[0], 4);
    check("clean_cnt", last_cnt[0], 4);

    // Backpressure: result held for 5 cycles while a beat is offered
    rmode[0] = 1;
    @(posedge clk);
    #3;
    send(0, 4, 1'b0);
    send(0, 4, 1'b1);
    fork
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_out_valid", int'(out_valid[0]), 1);
          check("bp_in_ready", int'(in_ready[0]), 0);
          check("bp_sum", osum[0], 8);
          check("bp_cnt", ocnt[0], 2);
        end
        rmode[0] = 2;
        t = 0;
        while (out_valid[0] && t < 20) begin
          @(negedge clk);
          t++;
        end
        check("bp_released", int'(out_valid[0]), 0);
        check("bp_ready_after_hs", int'(in_ready[0]), 1);
      end
      begin
        send(0, 3, 1'b1);
      end
    join
    wait_drain(0);
    check("bp_next_sum", last_sum[0], 3);
    check("bp_next_cnt", last_cnt[0], 1);

    // Overflow with ACC_W=5
    for (int i = 0; i < 4; i++) send(1, 9, 1'b0);
    wait_drain(1);
    check("ovf_sum", last_sum[1], 4);
    check("ovf_flag", last_ovf[1], 1);
    for (int i = 0; i < 4; i++) send(1, 1, 1'b0);
    wait_drain(1);
    check("ovf_clear_sum", last_sum[1], 4);
    check("ovf_clear_flag", last_ovf[1], 0);

    // Reset mid-group after two beats
    send(0, 5, 1'b0);
    send(0, 7, 1'b0);
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid[0]), 0);
    check("midrst_in_ready", int'(in_ready[0]), 0);
    check("midrst_sum", osum[0], 0);
    check("midrst_cnt", ocnt[0], 0);
    check("midrst_ovf", int'(out_ovf[0]), 0);
    rst_n[0] = 1'b1;
    psum[0]  = 0;
    pcnt[0]  = 0;
    for (int i = 1; i <= 4; i++) send(0, i, 1'b0);
    wait_drain(0);
    check("postrst_sum", last_sum[0], 10);
    check("postrst_cnt", last_cnt[0], 4);

    // Gapped input 2,_,_,5,_,7,1
    send(0, 2, 1'b0);
    idle(2);
    send(0, 5, 1'b0);
    idle(1);
    send(0, 7, 1'b0);
    send(0, 1, 1'b0);
    wait_drain(0);
    check("gap_sum", last_sum[0], 15);
    check("gap_cnt", last_cnt[0], 4);

    // NUM_TERMS=1: each beat is its own group
    send(2, 3, 1'b0);
    send(2, 7, 1'b0);
    send(2, 15, 1'b0);
    wait_drain(2);
    check("nt1_sum", last_sum[2], 15);
    check("nt1_cnt", last_cnt[2], 1);

    // Randomized traffic with random consumer stalls on all instances
    for (int k = 0; k < 3; k++) rmode[k] = 0;
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    for (int k = 0; k < 3; k++) rmode[k] = 2;
    for (int k = 0; k < 3; k++) wait_drain(k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
